// File: rtl/comparator_bist.sv
// Exhaustive on-chip self-test for a WIDTH-bit magnitude comparator: sweeps every
// {A,B} pair, checks G/E/L against the unsigned relation, counts and logs failures.
module comparator_bist #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  input  logic               G,
  input  logic               E,
  input  logic               L,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int CW = 2 * WIDTH;
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   fa_q, fa_d, fb_q, fb_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [CW:0]        err_q, err_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0]         exp_gel;
  logic               mismatch;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    // Expected response is taken from the operands actually driven, not from cnt
    exp_gel  = {a_q > b_q, a_q == b_q, a_q < b_q};
    mismatch = ({G, E, L} != exp_gel);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d   = '0;
          err_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        a_d     = cnt_q[CW-1:WIDTH];
        b_d     = cnt_q[WIDTH-1:0];
        wcnt_d  = '0;
        state_d = (SETTLE > 0) ? S_WAIT : S_CHECK;
      end
      S_WAIT: begin
        if (wcnt_q == WW'(SETTLE - 1)) state_d = S_CHECK;
        else                           wcnt_d  = wcnt_q + 1'b1;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fa_d = a_q;
            fb_d = b_q;
          end
        end
        if (&cnt_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      wcnt_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign err_count = err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: two instances (SETTLE=1 and SETTLE=0) each beside a
// behavioural comparator with selectable faults; sweep results go through a queue.
module tb_comparator_bist;

  logic clk = 1'b0;
  logic rst;
  logic st0, st1;
  logic [3:0] a0, b0, a1, b1, fa0, fb0, fa1, fb1;
  logic g0, e0, l0, g1, e1, l1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [8:0] ec0, ec1;
  logic [2:0] lat0, lat1;
  int mode0, mode1;
  int cyc = 0;
  int nerr = 0, ncheck = 0;
  bit overlap = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // mode 0 good, 1 G stuck low, 2 E and L both high on equality, 3 one-cycle latency
  function automatic logic [2:0] cmp(int m, logic [3:0] a, logic [3:0] b);
    logic [2:0] r;
    r = {a > b, a == b, a < b};
    if (m == 1) r[2] = 1'b0;
    if (m == 2 && a == b) r[0] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    lat0 <= cmp(0, a0, b0);
    lat1 <= cmp(0, a1, b1);
  end
  assign {g0, e0, l0} = (mode0 == 3) ? lat0 : cmp(mode0, a0, b0);
  assign {g1, e1, l1} = (mode1 == 3) ? lat1 : cmp(mode1, a1, b1);

  always @(negedge clk) if ((busy0 && done0) || (busy1 && done1)) overlap = 1;

  comparator_bist #(.WIDTH(4), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(st0), .A(a0), .B(b0), .G(g0), .E(e0), .L(l0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
    .fail_a(fa0), .fail_b(fb0));

  comparator_bist #(.WIDTH(4), .SETTLE(0)) u1 (
    .clk(clk), .rst(rst), .start(st1), .A(a1), .B(b1), .G(g1), .E(e1), .L(l1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .fail_a(fa1), .fail_b(fb1));

  typedef struct {
    int inst; int mode; int len; int err; bit err_nz; bit pass; bit chk_fail; int fa; int fb;
  } vec_t;
  vec_t tbl[6];
  vec_t sbq[$];

  task automatic chk(string nm, int act, int exp);
    ncheck++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_start(int inst, logic v);
    if (inst == 0) st0 = v; else st1 = v;
  endtask

  task automatic rd(int inst, output int bsy, output int dn, output int ps,
                    output int ec, output int fa, output int fb);
    if (inst == 0) begin bsy = busy0; dn = done0; ps = pass0; ec = ec0; fa = fa0; fb = fb0; end
    else           begin bsy = busy1; dn = done1; ps = pass1; ec = ec1; fa = fa1; fb = fb1; end
  endtask

  // Start a sweep, optionally re-pulse start mid-run, then score against the queue
  task automatic run_sweep(int r, int restart_at);
    vec_t v, e;
    int t0, len, bsy, dn, ps, ec, fa, fb;
    v = tbl[r];
    if (v.inst == 0) mode0 = v.mode; else mode1 = v.mode;
    sbq.push_back(v);
    @(negedge clk) set_start(v.inst, 1'b1);
    @(negedge clk) set_start(v.inst, 1'b0);
    t0 = cyc;
    rd(v.inst, bsy, dn, ps, ec, fa, fb);
    chk($sformatf("r%0d busy_after_start", r), bsy, 1);
    chk($sformatf("r%0d done_cleared", r), dn, 0);
    chk($sformatf("r%0d err_cleared", r), ec, 0);
    chk($sformatf("r%0d fail_cleared", r), fa * 16 + fb, 0);
    len = -1;
    for (int i = 1; i < 2000; i++) begin
      @(negedge clk);
      if (restart_at > 0 && i == restart_at)     set_start(v.inst, 1'b1);
      if (restart_at > 0 && i == restart_at + 1) set_start(v.inst, 1'b0);
      rd(v.inst, bsy, dn, ps, ec, fa, fb);
      if (dn) begin len = cyc - t0; break; end
    end
    e = sbq.pop_front();
    chk($sformatf("r%0d sweep_len", r), len, e.len);
    if (e.err_nz) chk($sformatf("r%0d err_nonzero", r), int'(ec != 0), 1);
    else          chk($sformatf("r%0d err_count", r), ec, e.err);
    chk($sformatf("r%0d pass", r), ps, int'(e.pass));
    chk($sformatf("r%0d busy_at_done", r), bsy, 0);
    if (e.chk_fail) begin
      chk($sformatf("r%0d fail_a", r), fa, e.fa);
      chk($sformatf("r%0d fail_b", r), fb, e.fb);
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 768, 0,   0, 1, 1, 0, 0};
    tbl[1] = '{0, 1, 768, 120, 0, 0, 1, 1, 0};
    tbl[2] = '{0, 2, 768, 16,  0, 0, 1, 0, 0};
    tbl[3] = '{1, 0, 512, 0,   0, 1, 1, 0, 0};
    tbl[4] = '{1, 3, 512, 0,   1, 0, 0, 0, 0};
    tbl[5] = '{0, 3, 768, 0,   0, 1, 1, 0, 0};

    mode0 = 0; mode1 = 0;
    rst = 1'b1; st0 = 1'b0; st1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_a_b", int'({a0, b0}), 0);
    chk("reset_flags", int'({busy0, done0, pass0}), 0);
    chk("reset_err", int'(ec0), 0);
    chk("reset_fail", int'({fa0, fb0}), 0);
    rst = 1'b0;

    run_sweep(0, 0);
    run_sweep(1, 0);
    run_sweep(0, 0);    // start from DONE after a failing sweep
    run_sweep(2, 0);
    run_sweep(0, 300);  // start while busy must be ignored

    // Reset at cycle 100 of a sweep
    mode0 = 0;
    @(negedge clk) st0 = 1'b1;
    @(negedge clk) st0 = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy_done", int'({busy0, done0}), 0);
    chk("midrst_err", int'(ec0), 0);
    chk("midrst_a_b", int'({a0, b0}), 0);
    rst = 1'b0;
    run_sweep(0, 0);

    run_sweep(5, 0);
    run_sweep(3, 0);
    run_sweep(4, 0);

    chk("busy_done_exclusive", int'(overlap), 0);
    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end

endmodule
